// File: rtl/mdom_wvb_writer.sv
// mDOM waveform-buffer writer.
// Turns each accepted trigger into one contiguous waveform of samples:
// pre-trigger samples are taken from a delay line, and the waveform ends
// after post_conf samples (fixed mode) or once ToT drops (extend mode).
// One header (timestamp, source, length) is emitted with the last word.
module mdom_wvb_writer #(
    parameter int P_PRE_MAX   = 32,
    parameter int P_MAX_LEN   = 4095,
    parameter int P_LTC_WIDTH = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [11:0]            adc_stream_in,
    input  logic [7:0]             discr_stream_in,
    input  logic                   trig,
    input  logic [1:0]             trig_src,
    input  logic                   thresh_tot,
    input  logic                   discr_tot,
    input  logic [P_LTC_WIDTH-1:0] ltc_in,
    input  logic                   arm,
    input  logic                   cnst_run,
    input  logic [4:0]             pre_conf,
    input  logic [11:0]            post_conf,
    input  logic                   wvb_full,
    output logic                   wvb_wr_en,
    output logic [21:0]            wvb_data,
    output logic                   hdr_valid,
    output logic [P_LTC_WIDTH-1:0] hdr_ltc,
    output logic [1:0]             hdr_src,
    output logic [12:0]            hdr_len,
    output logic                   armed,
    output logic                   overflow
);

    localparam int LP_WORD_W = 21;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_ARMED   = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [LP_WORD_W-1:0]   r_dly [P_PRE_MAX];

    logic [4:0]             r_pre;
    logic [11:0]            r_post;
    logic                   r_cnst;
    logic [5:0]             r_fill;
    logic [12:0]            r_k;
    logic [P_LTC_WIDTH-1:0] r_ltc_lat;
    logic [1:0]             r_src_lat;

    logic                   r_wr_en;
    logic [21:0]            r_data;
    logic                   r_hdr_valid;
    logic [P_LTC_WIDTH-1:0] r_hdr_ltc;
    logic [1:0]             r_hdr_src;
    logic [12:0]            r_hdr_len;
    logic                   r_ovf;

    logic [LP_WORD_W-1:0]   w_word;
    logic [LP_WORD_W-1:0]   w_tap;
    logic [12:0]            w_k;
    logic [12:0]            w_span;
    logic                   w_last;
    logic                   w_eoe_out;
    logic                   w_start;
    logic                   w_accept;
    logic                   w_drop;
    logic                   w_load;

    // Sample word as stored in the buffer (eoe bit is added on write).
    assign w_word = {thresh_tot | discr_tot, discr_stream_in, adc_stream_in};

    // Delay line shifts every cycle regardless of state, so it is always
    // primed once FILL has waited pre+1 cycles; contents need no reset.
    always_ff @(posedge clk) begin
        r_dly[0] <= w_word;
        for (int i = 1; i < P_PRE_MAX; i++) begin
            r_dly[i] <= r_dly[i-1];
        end
    end

    // Tap chosen so that, with the output register, the total delay is pre+1.
    assign w_tap = (r_pre == 5'd0) ? w_word : r_dly[r_pre - 5'd1];

    // Index of the sample being loaded this cycle: 0 on acceptance.
    assign w_k    = (r_state == S_CAPTURE) ? r_k : 13'd0;
    assign w_span = 13'(r_pre) + 13'(r_post);

    // End-of-event decision for the sample being loaded (j = k - pre).
    assign w_last = (r_cnst  && (w_k == w_span))
                 || (!r_cnst && (w_k >= w_span) && !w_tap[LP_WORD_W-1])
                 || (w_k == 13'(P_MAX_LEN - 1));

    // The eoe word is on the output this cycle; CAPTURE ends here.
    assign w_eoe_out = r_wr_en & r_data[21];

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_state_nxt = S_FILL;
                    w_start     = 1'b1;
                end
            end
            S_FILL: begin
                if (!arm) begin
                    w_state_nxt = S_IDLE;
                end else if (r_fill == (6'(r_pre) + 6'd1)) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                // arm low wins over a simultaneous trigger
                if (!arm) begin
                    w_state_nxt = S_IDLE;
                end else if (trig) begin
                    if (wvb_full) begin
                        w_drop = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                // trig and arm are not looked at until the event completes
                if (w_eoe_out) begin
                    w_state_nxt = arm ? S_ARMED : S_IDLE;
                end else begin
                    w_load = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, latched configuration, and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pre       <= '0;
            r_post      <= '0;
            r_cnst      <= 1'b0;
            r_fill      <= '0;
            r_k         <= '0;
            r_ltc_lat   <= '0;
            r_src_lat   <= '0;
            r_wr_en     <= 1'b0;
            r_data      <= '0;
            r_hdr_valid <= 1'b0;
            r_hdr_ltc   <= '0;
            r_hdr_src   <= '0;
            r_hdr_len   <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_en     <= w_load;
            r_hdr_valid <= w_load & w_last;

            if (w_start) begin
                r_pre  <= pre_conf;
                r_post <= post_conf;
                r_cnst <= cnst_run;
                r_fill <= '0;
                r_ovf  <= 1'b0;
            end else if (r_state == S_FILL) begin
                r_fill <= r_fill + 6'd1;
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end

            if (w_accept) begin
                r_ltc_lat <= ltc_in;
                r_src_lat <= trig_src;
            end

            if (w_load) begin
                r_k    <= w_k + 13'd1;
                r_data <= {w_last, w_tap};
            end

            // A single-sample event ends on the acceptance cycle itself,
            // so the header must take the live timestamp/source then.
            if (w_load && w_last) begin
                r_hdr_ltc <= w_accept ? ltc_in   : r_ltc_lat;
                r_hdr_src <= w_accept ? trig_src : r_src_lat;
                r_hdr_len <= w_k + 13'd1;
            end
        end
    end

    assign wvb_wr_en = r_wr_en;
    assign wvb_data  = r_data;
    assign hdr_valid = r_hdr_valid;
    assign hdr_ltc   = r_hdr_ltc;
    assign hdr_src   = r_hdr_src;
    assign hdr_len   = r_hdr_len;
    assign armed     = (r_state == S_ARMED);
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_mdom_wvb_writer.sv
// Self-checking bench for mdom_wvb_writer: inputs and outputs are logged per
// cycle, and a sample-history model predicts each event's writes and header.
module tb_mdom_wvb_writer;

    localparam int N   = 8192;
    localparam int LTW = 48;

    logic            clk = 1'b0;
    logic            rst;
    logic [11:0]     adc_stream_in;
    logic [7:0]      discr_stream_in;
    logic            trig;
    logic [1:0]      trig_src;
    logic            thresh_tot;
    logic            discr_tot;
    logic [LTW-1:0]  ltc_in;
    logic            arm;
    logic            cnst_run;
    logic [4:0]      pre_conf;
    logic [11:0]     post_conf;
    logic            wvb_full;
    logic            wvb_wr_en;
    logic [21:0]     wvb_data;
    logic            hdr_valid;
    logic [LTW-1:0]  hdr_ltc;
    logic [1:0]      hdr_src;
    logic [12:0]     hdr_len;
    logic            armed;
    logic            overflow;

    mdom_wvb_writer #(.P_PRE_MAX(32), .P_MAX_LEN(4095), .P_LTC_WIDTH(LTW)) dut (
        .clk(clk), .rst(rst), .adc_stream_in(adc_stream_in),
        .discr_stream_in(discr_stream_in), .trig(trig), .trig_src(trig_src),
        .thresh_tot(thresh_tot), .discr_tot(discr_tot), .ltc_in(ltc_in),
        .arm(arm), .cnst_run(cnst_run), .pre_conf(pre_conf),
        .post_conf(post_conf), .wvb_full(wvb_full), .wvb_wr_en(wvb_wr_en),
        .wvb_data(wvb_data), .hdr_valid(hdr_valid), .hdr_ltc(hdr_ltc),
        .hdr_src(hdr_src), .hdr_len(hdr_len), .armed(armed), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit ramp   = 1'b0;
    bit tot_rand = 1'b0;
    logic [LTW-1:0] ltc_base;

    // per-cycle log of what the DUT saw and produced
    logic [20:0]    hist_word [N];
    logic [LTW-1:0] hist_ltc  [N];
    logic [1:0]     hist_src  [N];
    logic           mon_wr    [N];
    logic [21:0]    mon_dat   [N];
    logic           mon_hv    [N];
    logic [LTW-1:0] mon_ltc   [N];
    logic [1:0]     mon_src   [N];
    logic [12:0]    mon_len   [N];

    // expected writes/headers per cycle
    logic           exp_wr    [N];
    logic [21:0]    exp_dat   [N];
    logic           exp_hv    [N];
    logic [LTW-1:0] exp_ltc   [N];
    logic [1:0]     exp_src   [N];
    logic [12:0]    exp_len   [N];

    // mid-cycle logging, well away from the active edge
    always @(negedge clk) begin
        if (cyc < N) begin
            hist_word[cyc] <= {thresh_tot | discr_tot, discr_stream_in, adc_stream_in};
            hist_ltc[cyc]  <= ltc_in;
            hist_src[cyc]  <= trig_src;
            mon_wr[cyc]    <= wvb_wr_en;
            mon_dat[cyc]   <= wvb_data;
            mon_hv[cyc]    <= hdr_valid;
            mon_ltc[cyc]   <= hdr_ltc;
            mon_src[cyc]   <= hdr_src;
            mon_len[cyc]   <= hdr_len;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        adc_stream_in   = ramp ? cyc[11:0] : 12'($urandom);
        discr_stream_in = 8'($urandom);
        trig_src        = 2'($urandom);
        ltc_in          = ltc_base + LTW'(cyc);
        if (tot_rand) begin
            thresh_tot = ($urandom % 2) == 1;
            discr_tot  = ($urandom % 2) == 1;
        end
    endtask

    task automatic clear_exp();
        for (int c = 0; c < N; c++) begin
            exp_wr[c] = 1'b0; exp_dat[c] = '0; exp_hv[c] = 1'b0;
            exp_ltc[c] = '0;  exp_src[c] = '0; exp_len[c] = '0;
        end
    endtask

    // Reference: trigger at cycle t writes samples t-pre, t-pre+1, ... at
    // cycles t+1, t+2, ... until the end-of-event rule is met.
    task automatic model_event(input int t, input int pre, input int post, input bit cnst);
        int k;
        bit last;
        logic [20:0] s;
        k = 0;
        last = 1'b0;
        while (!last) begin
            s = hist_word[t - pre + k];
            last = (cnst && (k - pre == post)) || (!cnst && (k - pre >= post) && !s[20])
                   || (k + 1 == 4095);
            exp_wr[t+1+k]  = 1'b1;
            exp_dat[t+1+k] = {last, s};
            if (last) begin
                exp_hv[t+1+k]  = 1'b1;
                exp_len[t+1+k] = 13'(k + 1);
                exp_ltc[t+1+k] = hist_ltc[t];
                exp_src[t+1+k] = hist_src[t];
            end
            k++;
        end
    endtask

    // drop to IDLE, load config, raise arm and wait until ARMED
    task automatic arm_cfg(input int pre, input int post, input bit cnst);
        arm = 1'b0;
        step(); step();
        pre_conf  = 5'(pre);
        post_conf = 12'(post);
        cnst_run  = cnst;
        arm = 1'b1;
        repeat (pre + 4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({wvb_wr_en, wvb_data, hdr_valid, hdr_ltc, hdr_src, hdr_len, armed, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got wr=%b data=%h hv=%b len=%0d armed=%b ovf=%b want all 0",
                     wvb_wr_en, wvb_data, hdr_valid, hdr_len, armed, overflow);
        end
        rst = 1'b0;
        step();
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle armed got %b want 0", armed);
        end
    endtask

    task automatic test_const();
        int t, c0, nwr;
        clear_exp();
        ramp = 1'b1;
        c0 = cyc;
        arm_cfg(3, 5, 1'b1);
        repeat (10) step();
        t = cyc;
        trig = 1'b1;
        step();
        trig = 1'b0;
        repeat (20) step();
        ramp = 1'b0;
        model_event(t, 3, 5, 1'b1);
        nwr = 0;
        for (int c = c0; c < cyc; c++) begin
            if (mon_wr[c] === 1'b1) nwr++;
            checks++;
            if (mon_wr[c] !== exp_wr[c] || (exp_wr[c] && mon_dat[c] !== exp_dat[c])) begin
                errors++;
                $display("FAIL const_wr cyc=%0d got wr=%b data=%h want wr=%b data=%h",
                         c, mon_wr[c], mon_dat[c], exp_wr[c], exp_dat[c]);
            end
            checks++;
            if (mon_hv[c] !== exp_hv[c] || (exp_hv[c] && (mon_len[c] !== exp_len[c]
                || mon_ltc[c] !== exp_ltc[c] || mon_src[c] !== exp_src[c]))) begin
                errors++;
                $display("FAIL const_hdr cyc=%0d got hv=%b len=%0d ltc=%h src=%0d want hv=%b len=%0d ltc=%h src=%0d",
                         c, mon_hv[c], mon_len[c], mon_ltc[c], mon_src[c], exp_hv[c], exp_len[c], exp_ltc[c], exp_src[c]);
            end
        end
        checks++;
        if (nwr != 9 || mon_dat[t+1][11:0] !== 12'(t - 3) || mon_dat[t+9][11:0] !== 12'(t + 5)) begin
            errors++;
            $display("FAIL const_ramp got writes=%0d first_adc=%0d last_adc=%0d want 9 %0d %0d",
                     nwr, mon_dat[t+1][11:0], mon_dat[t+9][11:0], (t - 3) % 4096, (t + 5) % 4096);
        end
        checks++;
        if (mon_hv[t+9] !== 1'b1 || mon_len[t+9] !== 13'd9 || mon_ltc[t+9] !== ltc_base + LTW'(t)) begin
            errors++;
            $display("FAIL const_header got hv=%b len=%0d ltc=%h want 1 9 %h",
                     mon_hv[t+9], mon_len[t+9], mon_ltc[t+9], ltc_base + LTW'(t));
        end
    endtask

    task automatic test_fill_ignore();
        int a, t, c0;
        clear_exp();
        arm = 1'b0;
        step(); step();
        pre_conf = 5'd3; post_conf = 12'd5; cnst_run = 1'b1;
        c0 = cyc;
        arm = 1'b1;
        a = cyc;
        step(); step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        while (cyc < a + 10) step();
        t = cyc;
        trig = 1'b1;
        step();
        trig = 1'b0;
        repeat (20) step();
        model_event(t, 3, 5, 1'b1);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (mon_wr[c] !== exp_wr[c] || (exp_wr[c] && mon_dat[c] !== exp_dat[c])) begin
                errors++;
                $display("FAIL fill_wr cyc=%0d got wr=%b data=%h want wr=%b data=%h",
                         c, mon_wr[c], mon_dat[c], exp_wr[c], exp_dat[c]);
            end
            checks++;
            if (mon_hv[c] !== exp_hv[c] || (exp_hv[c] && mon_len[c] !== exp_len[c])) begin
                errors++;
                $display("FAIL fill_hdr cyc=%0d got hv=%b len=%0d want hv=%b len=%0d",
                         c, mon_hv[c], mon_len[c], exp_hv[c], exp_len[c]);
            end
        end
    endtask

    task automatic test_extend_tot();
        int t, c0;
        clear_exp();
        c0 = cyc;
        arm_cfg(3, 2, 1'b0);
        repeat (3) step();
        t = cyc;
        thresh_tot = 1'b1;
        trig = 1'b1;
        step();
        trig = 1'b0;
        repeat (6) step();
        thresh_tot = 1'b0;
        repeat (25) step();
        model_event(t, 3, 2, 1'b0);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (mon_wr[c] !== exp_wr[c] || (exp_wr[c] && mon_dat[c] !== exp_dat[c])) begin
                errors++;
                $display("FAIL extend_wr cyc=%0d got wr=%b data=%h want wr=%b data=%h",
                         c, mon_wr[c], mon_dat[c], exp_wr[c], exp_dat[c]);
            end
        end
        checks++;
        if (mon_hv[t+11] !== 1'b1 || mon_len[t+11] !== 13'd11 || mon_dat[t+11][21] !== 1'b1) begin
            errors++;
            $display("FAIL extend_len got hv=%b len=%0d eoe=%b want 1 11 1",
                     mon_hv[t+11], mon_len[t+11], mon_dat[t+11][21]);
        end
    endtask

    task automatic test_back_to_back();
        int p, q, t1, t2, e, c0;
        clear_exp();
        p = int'($urandom_range(0, 7));
        q = int'($urandom_range(0, 6));
        c0 = cyc;
        arm_cfg(p, q, 1'b1);
        t1 = cyc;
        trig = 1'b1;
        step();
        trig = 1'b0;
        e = t1 + 1 + p + q;
        while (cyc < e) step();
        // eoe cycle is still CAPTURE: this trigger must be ignored entirely
        trig = 1'b1; wvb_full = 1'b1;
        step();
        wvb_full = 1'b0;
        t2 = cyc;
        step();
        trig = 1'b0;
        repeat (45) step();
        model_event(t1, p, q, 1'b1);
        model_event(t2, p, q, 1'b1);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (mon_wr[c] !== exp_wr[c] || (exp_wr[c] && mon_dat[c] !== exp_dat[c])) begin
                errors++;
                $display("FAIL b2b_wr cyc=%0d pre=%0d post=%0d got wr=%b data=%h want wr=%b data=%h",
                         c, p, q, mon_wr[c], mon_dat[c], exp_wr[c], exp_dat[c]);
            end
            checks++;
            if (mon_hv[c] !== exp_hv[c] || (exp_hv[c] && (mon_len[c] !== exp_len[c]
                || mon_ltc[c] !== exp_ltc[c] || mon_src[c] !== exp_src[c]))) begin
                errors++;
                $display("FAIL b2b_hdr cyc=%0d got hv=%b len=%0d src=%0d want hv=%b len=%0d src=%0d",
                         c, mon_hv[c], mon_len[c], mon_src[c], exp_hv[c], exp_len[c], exp_src[c]);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overflow got %b want 0", overflow);
        end
    endtask

    task automatic test_random();
        int p, q, t, c0;
        bit cn;
        for (int it = 0; it < 6; it++) begin
            clear_exp();
            p  = int'($urandom_range(0, 31));
            q  = int'($urandom_range(0, 15));
            cn = 1'($urandom);
            c0 = cyc;
            tot_rand = 1'b1;
            arm_cfg(p, q, cn);
            repeat (int'($urandom_range(0, 5))) step();
            t = cyc;
            trig = 1'b1;
            step();
            trig = 1'b0;
            repeat (130) step();
            tot_rand = 1'b0;
            thresh_tot = 1'b0; discr_tot = 1'b0;
            model_event(t, p, q, cn);
            for (int c = c0; c < cyc; c++) begin
                checks++;
                if (mon_wr[c] !== exp_wr[c] || (exp_wr[c] && mon_dat[c] !== exp_dat[c])) begin
                    errors++;
                    $display("FAIL rand_wr it=%0d cyc=%0d pre=%0d post=%0d cnst=%b got wr=%b data=%h want wr=%b data=%h",
                             it, c, p, q, cn, mon_wr[c], mon_dat[c], exp_wr[c], exp_dat[c]);
                end
                checks++;
                if (mon_hv[c] !== exp_hv[c] || (exp_hv[c] && (mon_len[c] !== exp_len[c]
                    || mon_ltc[c] !== exp_ltc[c] || mon_src[c] !== exp_src[c]))) begin
                    errors++;
                    $display("FAIL rand_hdr it=%0d cyc=%0d got hv=%b len=%0d want hv=%b len=%0d",
                             it, c, mon_hv[c], mon_len[c], exp_hv[c], exp_len[c]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int c0;
        clear_exp();
        c0 = cyc;
        arm_cfg(1, 2, 1'b1);
        wvb_full = 1'b1;
        trig = 1'b1;
        step();
        trig = 1'b0; wvb_full = 1'b0;
        repeat (10) step();
        checks++;
        if (overflow !== 1'b1 || armed !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got ovf=%b armed=%b want 1 1", overflow, armed);
        end
        // arm low together with trig: arm wins, no event
        trig = 1'b1; arm = 1'b0;
        step();
        trig = 1'b0;
        repeat (10) step();
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (mon_wr[c] !== 1'b0 || mon_hv[c] !== 1'b0) begin
                errors++;
                $display("FAIL ovf_nowrite cyc=%0d got wr=%b hv=%b want 0 0", c, mon_wr[c], mon_hv[c]);
            end
        end
        checks++;
        if (overflow !== 1'b1 || armed !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky got ovf=%b armed=%b want 1 0", overflow, armed);
        end
        arm = 1'b1;
        step();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0", overflow);
        end
        repeat (8) step();
    endtask

    task automatic test_cap();
        int t, c0;
        clear_exp();
        thresh_tot = 1'b1;
        c0 = cyc;
        arm_cfg(31, 4090, 1'b0);
        repeat (2) step();
        t = cyc;
        trig = 1'b1;
        step();
        trig = 1'b0;
        repeat (4110) step();
        thresh_tot = 1'b0;
        model_event(t, 31, 4090, 1'b0);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (mon_wr[c] !== exp_wr[c] || (exp_wr[c] && mon_dat[c] !== exp_dat[c])
                || mon_hv[c] !== exp_hv[c]) begin
                errors++;
                if (errors < 40)
                    $display("FAIL cap_wr cyc=%0d got wr=%b data=%h hv=%b want wr=%b data=%h hv=%b",
                             c, mon_wr[c], mon_dat[c], mon_hv[c], exp_wr[c], exp_dat[c], exp_hv[c]);
            end
        end
        checks++;
        if (mon_hv[t+4095] !== 1'b1 || mon_len[t+4095] !== 13'd4095 || mon_dat[t+4095][21] !== 1'b1) begin
            errors++;
            $display("FAIL cap_len got hv=%b len=%0d eoe=%b want 1 4095 1",
                     mon_hv[t+4095], mon_len[t+4095], mon_dat[t+4095][21]);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        clear_exp();
        arm_cfg(2, 20, 1'b1);
        trig = 1'b1;
        step();
        trig = 1'b0;
        repeat (5) step();
        checks++;
        if (wvb_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_active got wr=%b want 1", wvb_wr_en);
        end
        rst = 1'b1; arm = 1'b0;
        step();
        rst = 1'b0;
        checks++;
        if ({wvb_wr_en, wvb_data, hdr_valid, hdr_ltc, hdr_src, hdr_len, armed, overflow} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got wr=%b data=%h hv=%b len=%0d armed=%b ovf=%b want all 0",
                     wvb_wr_en, wvb_data, hdr_valid, hdr_len, armed, overflow);
        end
        c0 = cyc;
        repeat (30) step();
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (mon_wr[c] !== 1'b0 || mon_hv[c] !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_quiet cyc=%0d got wr=%b hv=%b want 0 0", c, mon_wr[c], mon_hv[c]);
            end
        end
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle armed got %b want 0", armed);
        end
    endtask

    initial begin
        ltc_base = LTW'({$urandom(), $urandom()});
        rst = 1'b1; trig = 1'b0; trig_src = '0; thresh_tot = 1'b0; discr_tot = 1'b0;
        adc_stream_in = '0; discr_stream_in = '0; ltc_in = ltc_base;
        arm = 1'b0; cnst_run = 1'b1; pre_conf = '0; post_conf = '0; wvb_full = 1'b0;
        test_reset();
        test_const();
        test_fill_ignore();
        test_extend_tot();
        test_back_to_back();
        test_random();
        test_overflow();
        test_cap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdom_wvb_writer.md
Name: mdom_wvb_writer

Overview:
- Consumer end of the mDOM trigger path. Takes the registered ADC/discriminator stream and the `trig`/`trig_src`/ToT outputs of the trigger block, and writes one waveform per accepted trigger into the downstream waveform buffer (WVB).
- Each waveform contains a programmable number of pre-trigger and post-trigger samples.
- In non-constant mode the waveform extends while ToT stays high.
- One header word (LTC timestamp, trigger source, length) is emitted per waveform.

Parameters:
- P_PRE_MAX, 32, depth of the pre-trigger delay line; pre_conf must be below this value.
- P_MAX_LEN, 4095, hard cap on samples per event.
- P_LTC_WIDTH, 48, timestamp width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- adc_stream_in  in  12  ADC sample, aligned with trig
- discr_stream_in  in  8  discriminator bits, aligned with trig
- trig  in  1  one-cycle trigger strobe
- trig_src  in  2  trigger source, valid when trig=1
- thresh_tot  in  1  threshold ToT, aligned with sample
- discr_tot  in  1  discriminator ToT, aligned with sample
- ltc_in  in  P_LTC_WIDTH  local time counter
- arm  in  1  enable acquisition (level)
- cnst_run  in  1  1 = fixed length; 0 = extend on ToT
- pre_conf  in  5  pre-trigger samples (0..P_PRE_MAX-1)
- post_conf  in  12  post-trigger samples
- wvb_full  in  1  downstream buffer cannot take a full event
- wvb_wr_en  out  1  write strobe
- wvb_data  out  22  {eoe, tot, discr[7:0], adc[11:0]}
- hdr_valid  out  1  one-cycle header strobe
- hdr_ltc  out  P_LTC_WIDTH  ltc_in captured at trig cycle
- hdr_src  out  2  latched trig_src
- hdr_len  out  13  samples written for the event
- armed  out  1  high in ARMED state
- overflow  out  1  sticky: trigger dropped because wvb_full was high

Behaviour:
- Reset: all outputs 0, state IDLE, fill counter 0, delay line contents don't-care. Reset mid-event aborts the event with no eoe and no header.
- Sample word: {tot = thresh_tot|discr_tot, discr, adc}. The word is delayed by exactly pre_conf+1 cycles through the delay line, which shifts every cycle regardless of state.
- States:
  - IDLE:
    - arm=1 → FILL; latch pre_conf, post_conf, cnst_run; clear fill_cnt.
  - FILL:
    - fill_cnt increments each cycle.
    - fill_cnt==pre_conf+1 → ARMED.
    - arm=0 → IDLE.
    - trig is ignored.
  - ARMED:
    - trig=1 and wvb_full=0 → CAPTURE; latch ltc_in and trig_src; sample index k=0.
    - trig=1 and wvb_full=1 → set overflow, stay in ARMED.
    - arm=0 → IDLE.
  - CAPTURE:
    - For trig on cycle t, the first write is at t+1 and carries sample −pre_conf.
    - One write per cycle follows, with no gaps; k counts samples written.
    - The write of sample index j (relative to the trig sample, j=k−pre_conf) is the last when any of these holds:
      - cnst_run=1 and j==post_conf;
      - cnst_run=0 and j≥post_conf and that sample's tot=0;
      - k+1==P_MAX_LEN (cap).
    - The last write has eoe=1.
    - On the same cycle: hdr_valid=1, hdr_len=k+1, hdr_ltc/hdr_src hold the latched values.
    - Next state: ARMED if arm=1, else IDLE. The delay line stays full, so no refill is needed.
    - trig during CAPTURE is ignored and does not set overflow.
    - arm falling mid-capture: the event completes normally.
- Latched config stays fixed until the next IDLE→FILL transition.
- overflow clears on rst or on the IDLE→FILL transition.
- wvb_full is sampled only at trigger acceptance. Downstream must assert it with at least P_MAX_LEN words of headroom.
- Simultaneous arm=0 and trig in ARMED: arm has priority → IDLE, no event.
- Back-to-back: trig on the cycle after the eoe write, with state ARMED, is accepted.
- wvb_data and hdr_* are registered; hdr_* hold their values until the next header.

Test Plan:
- arm=1, pre_conf=3, post_conf=5, cnst_run=1, ramp ADC (adc=cycle count), trig at cycle 20 → 9 writes at cycles 21..29 carrying adc 17..25; eoe and hdr_valid at 29; hdr_len=9; hdr_ltc = ltc at cycle 20.
- Same config, trig at cycle 2 after arm (during FILL) → no writes; trig at cycle 10 → event accepted.
- cnst_run=0, post_conf=2, thresh_tot high for samples 0..6 → last sample j=7, hdr_len=3+8=11.
- cnst_run=0, post_conf=4090, pre_conf=31, tot held high → capped at hdr_len=4095 with eoe.
- wvb_full=1 at trig → no writes, overflow=1; re-arm (arm 0→1) clears overflow.
- rst pulse mid-CAPTURE → wvb_wr_en=0 next cycle, no hdr_valid, state IDLE, all outputs 0.
